// File: rtl/tdm_mux_8_1.sv
// 8:1 time-division multiplexer: captures din and serializes it LSB first, one slot per cycle.
// Optional even-parity slot after slot 7 when TDM_MUX_PARITY_EN is defined.
module tdm_mux_8_1 #(
    parameter int GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       start,
    input  logic       cont,
    output logic       dout,
    output logic [2:0] sel_out,
    output logic       valid,
    output logic       frame_start,
    output logic       busy,
    output logic       done
);

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
`ifdef TDM_MUX_PARITY_EN
        , PAR = 2'd3
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] gap_q, gap_d;
    logic       dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       fs_q, fs_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       load;
    logic       frame_end;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        sel_d     = sel_q;
        gap_d     = gap_q;
        dout_d    = 1'b0;
        valid_d   = 1'b0;
        fs_d      = 1'b0;
        done_d    = 1'b0;
        load      = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            IDLE: load = start;
            SHIFT: begin
                if (sel_q != 3'd7) begin
                    sel_d   = 3'(sel_q + 3'd1);
                    dout_d  = shadow_q[sel_d];
                    valid_d = 1'b1;
                end else begin
`ifdef TDM_MUX_PARITY_EN
                    state_d = PAR;
                    sel_d   = 3'd0;
                    dout_d  = ^shadow_q;
                    valid_d = 1'b1;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef TDM_MUX_PARITY_EN
            // The parity slot is the last slot, so cont is sampled here.
            PAR: frame_end = 1'b1;
`endif
            GAP: begin
                if (gap_q == 4'd0) load = 1'b1;
                else gap_d = 4'(gap_q - 4'd1);
            end
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            if (cont) begin
                if (GAP_CYCLES == 0) begin
                    load = 1'b1;
                end else begin
                    state_d = GAP;
                    sel_d   = 3'd0;
                    gap_d   = GAP_LAST;
                end
            end else begin
                state_d = IDLE;
                sel_d   = 3'd0;
                done_d  = 1'b1;
            end
        end

        // Slot 0 of a new frame is driven straight from din at the capture edge.
        if (load) begin
            shadow_d = din;
            state_d  = SHIFT;
            sel_d    = 3'd0;
            gap_d    = 4'd0;
            dout_d   = din[0];
            valid_d  = 1'b1;
            fs_d     = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= 8'd0;
            sel_q    <= 3'd0;
            gap_q    <= 4'd0;
            dout_q   <= 1'b0;
            valid_q  <= 1'b0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            sel_q    <= sel_d;
            gap_q    <= gap_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            fs_q     <= fs_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign dout        = dout_q;
    assign sel_out     = sel_q;
    assign valid       = valid_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tdm_mux_8_1.sv
module tb_tdm_mux_8_1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       start;
  logic       cont;

  logic       dout0, valid0, fs0, busy0, done0;
  logic [2:0] sel0;
  logic       dout3, valid3, fs3, busy3, done3;
  logic [2:0] sel3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tdm_mux_8_1 #(.GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .start(start), .cont(cont),
    .dout(dout0), .sel_out(sel0), .valid(valid0), .frame_start(fs0),
    .busy(busy0), .done(done0)
  );

  tdm_mux_8_1 #(.GAP_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .din(din), .start(start), .cont(cont),
    .dout(dout3), .sel_out(sel3), .valid(valid3), .frame_start(fs3),
    .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  pat;
    logic [7:0]  acc8;
    logic [15:0] acc16a, acc16b;
    logic [19:0] vpat;
    int          nfs, ndone, nb;

    rst_n = 1'b0; din = 8'h00; start = 1'b0; cont = 1'b0;
    step(); step();
    chk("reset_outs0", {dout0, sel0, valid0, fs0, busy0, done0}, 8'h00);
    chk("reset_outs3", {dout3, sel3, valid3, fs3, busy3, done3}, 8'h00);
    rst_n = 1'b1;
    step();
    chk("idle_outs", {dout0, sel0, valid0, fs0, busy0, done0}, 8'h00);

    pat = 8'b1010_0110;
    din = pat; start = 1'b1;
    step();
    start = 1'b0;
    chk("sf_slot0", {dout0, sel0, valid0, fs0, busy0, done0}, {1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    for (int j = 1; j < 8; j++) begin
      step();
      chk("sf_slot", {dout0, sel0, valid0, fs0, busy0, done0}, {pat[j], 3'(j), 1'b1, 1'b0, 1'b1, 1'b0});
    end
    step();
    chk("sf_done0", {dout0, sel0, valid0, fs0, busy0, done0}, {1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1});
    chk("sf_done3", done3, 1'b1);
    step();
    chk("sf_done_pulse", done0, 1'b0);

    din = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    acc8 = 8'h00;
    acc8[0] = dout0;
    for (int j = 1; j < 8; j++) begin
      if (j == 1) din = 8'h00;
      step();
      acc8[j] = dout0;
    end
    chk("iso_bits", acc8, 8'hFF);
    step();
    chk("iso_done", done0, 1'b1);
    step();

    din = 8'h5A; start = 1'b1;
    step();
    start = 1'b0;
    nfs = 1; ndone = 0;
    for (int j = 1; j < 16; j++) begin
      if (j == 3) start = 1'b1;
      step();
      start = 1'b0;
      if (j == 3) chk("busy_sel3", sel0, 3'd3);
      if (fs0) nfs++;
      if (done0) ndone++;
    end
    chk("busy_nfs", nfs, 1);
    chk("busy_ndone", ndone, 1);

    din = 8'h0F; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    din = 8'hF0;
    acc16a = '0; acc16b = '0; vpat = '0; nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) step();
      if (i == 8) cont = 1'b0;
      if (i < 16) begin
        acc16a[i] = dout0;
        chk("c0_valid", valid0, 1'b1);
        chk("c0_fs", fs0, (i == 0 || i == 8));
        chk("c0_nodone", done0, 1'b0);
      end
      if (i == 16) chk("c0_done", done0, 1'b1);
      vpat[i] = valid3;
      if (valid3) begin
        acc16b[nb] = dout3;
        nb++;
      end
      if (i >= 8 && i <= 10)
        chk("c3_gap", {dout3, sel3, busy3, done3}, {1'b0, 3'd0, 1'b1, 1'b0});
      if (i == 11) chk("c3_fs", fs3, 1'b1);
    end
    chk("c0_stream", acc16a, 16'hF00F);
    chk("c3_vpat", vpat, 20'b0111_1111_1000_1111_1111);
    chk("c3_stream", acc16b, 16'hF00F);
    chk("c3_done", {done3, busy3}, 2'b10);
    step(); step();

    din = 8'hC3; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst_n = 1'b0;
    step();
    chk("rst_mid0", {dout0, sel0, valid0, fs0, busy0, done0}, 8'h00);
    chk("rst_mid3", {dout3, sel3, valid3, fs3, busy3, done3}, 8'h00);
    rst_n = 1'b1; din = 8'h81; start = 1'b1;
    step();
    start = 1'b0;
    chk("rst_restart", {dout0, sel0, valid0, fs0, busy0, done0}, {1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    ndone = 0; acc8 = 8'h00; acc8[0] = dout0;
    for (int j = 1; j < 10; j++) begin
      step();
      if (j < 8) acc8[j] = dout0;
      if (done0) ndone++;
    end
    chk("rst_frame", acc8, 8'h81);
    chk("rst_ndone", ndone, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
